// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER);
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Magnitude of a two's-complement value when signed_mode is set, else passthrough.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x,
                                                   input logic signed_mode);
    return (signed_mode && x[DIV_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial subtract, select.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem,
  input  logic                 dividend_bit,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_next,
  output logic                 q_bit
);

  logic [DIV_WIDTH+1:0] shifted;
  logic [DIV_WIDTH+1:0] diff;

  // One extra bit of headroom so the sign of the trial difference is unambiguous.
  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {2'b00, divisor};

  always_comb begin
    q_bit    = ~diff[DIV_WIDTH+1];
    rem_next = q_bit ? diff[DIV_WIDTH:0] : shifted[DIV_WIDTH:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned 32-bit restoring divider with enable handshake.
// Optional DIVIDER_EARLY_OUT_EN skips the iteration for divide-by-zero and signed overflow.
module divider
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 is_unsign,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 done,
  output logic                 busy
);

  div_state_e           state;
  logic [CNT_W-1:0]     count;
  logic [DIV_WIDTH-1:0] a_reg;
  logic [DIV_WIDTH-1:0] dvd_reg;
  logic [DIV_WIDTH-1:0] dvs_reg;
  logic [DIV_WIDTH:0]   rem_reg;
  logic [DIV_WIDTH-1:0] q_reg;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic                 ovf;

  logic [DIV_WIDTH:0]   rem_next;
  logic                 q_bit;
  logic                 div_zero_now;
  logic                 ovf_now;

  assign div_zero_now = (b == '0);
  assign ovf_now      = ~is_unsign && (a == 32'h80000000) && (b == 32'hFFFFFFFF);

  div_step u_step (
    .rem          (rem_reg),
    .dividend_bit (dvd_reg[DIV_WIDTH-1]),
    .divisor      (dvs_reg),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      a_reg     <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (enable) begin
            a_reg    <= a;
            dvd_reg  <= abs_val(a, ~is_unsign);
            dvs_reg  <= abs_val(b, ~is_unsign);
            neg_q    <= ~is_unsign & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]);
            neg_r    <= ~is_unsign & a[DIV_WIDTH-1];
            div_zero <= div_zero_now;
            ovf      <= ovf_now;
            rem_reg  <= '0;
            q_reg    <= '0;
            count    <= '0;
            busy     <= 1'b1;
`ifdef DIVIDER_EARLY_OUT_EN
            state    <= (div_zero_now || ovf_now) ? FIX : CALC;
`else
            state    <= CALC;
`endif
          end
        end

        CALC: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem_reg <= rem_next;
            q_reg   <= {q_reg[DIV_WIDTH-2:0], q_bit};
            dvd_reg <= {dvd_reg[DIV_WIDTH-2:0], 1'b0};
            count   <= count + 1'b1;
            if (count == CNT_W'(DIV_ITER - 1))
              state <= FIX;
          end
        end

        FIX: begin
          busy <= 1'b0;
          if (!enable) begin
            state <= IDLE;
          end else begin
            // Special cases are resolved here so both builds produce identical results.
            if (div_zero) begin
              quotient  <= DIV_BY_ZERO_Q;
              remainder <= a_reg;
            end else if (ovf) begin
              quotient  <= 32'h80000000;
              remainder <= '0;
            end else begin
              quotient  <= neg_q ? -q_reg : q_reg;
              remainder <= neg_r ? -rem_reg[DIV_WIDTH-1:0] : rem_reg[DIV_WIDTH-1:0];
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy <= 1'b0;
          if (!enable) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Table-driven bench for divider plus hand-written abort, reset and hold sequences.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        is_unsign;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif
  localparam int FULL_LAT = 34;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .is_unsign (is_unsign),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge; the following cycle is the accept cycle T.
  task automatic start_op(input logic u, input logic [31:0] av, input logic [31:0] bv);
    enable    = 1'b1;
    is_unsign = u;
    a         = av;
    b         = bv;
  endtask

  // Counts edges from cycle T until done is seen, bounded.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk({nm, "_busy"}, 32'(busy), 32'd1);
    end while (!done && n < 80);
  endtask

  task automatic watch_no_done(input string nm, input int cycles);
    int seen_done = 0;
    int seen_busy = 0;
    repeat (cycles) begin
      tick();
      if (done) seen_done = 1;
      if (busy) seen_busy = 1;
    end
    chk({nm, "_no_done"}, 32'(seen_done), 32'd0);
    chk({nm, "_no_busy"}, 32'(seen_busy), 32'd0);
  endtask

  initial begin
    int n;
    string nm;

    //        is_u  a             b             q             r             lat
    vecs[0]  = '{1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        FULL_LAT};
    vecs[1]  = '{1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, FULL_LAT};
    vecs[2]  = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        EO_LAT};
    vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        EO_LAT};
    vecs[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        EO_LAT};
    vecs[5]  = '{1'b0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        FULL_LAT};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        FULL_LAT};
    vecs[7]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, FULL_LAT};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, FULL_LAT};
    vecs[9]  = '{1'b1, 32'd9,        32'd3,        32'd3,        32'd0,        FULL_LAT};
    vecs[10] = '{1'b0, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8, EO_LAT};

    rst = 1'b1; enable = 1'b0; is_unsign = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("rst_quotient",  quotient,       32'd0);
    chk("rst_remainder", remainder,      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("vec%0d", i);
      start_op(vecs[i].is_u, vecs[i].a, vecs[i].b);
      wait_done(nm, n);
      chk({nm, "_latency"},   32'(n),    32'(vecs[i].lat));
      chk({nm, "_quotient"},  quotient,  vecs[i].q);
      chk({nm, "_remainder"}, remainder, vecs[i].r);
      enable = 1'b0;
      tick();
      chk({nm, "_done_drop"}, 32'(done), 32'd0);
      $display("vec%0d u=%0b a=%h b=%h -> q=%h r=%h lat=%0d", i, vecs[i].is_u,
               vecs[i].a, vecs[i].b, quotient, remainder, n);
    end

    // Abort mid-CALC: outputs keep the previous result and done never fires.
    start_op(1'b1, 32'd100, 32'd7);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    chk("abort_busy",      32'(busy), 32'd0);
    chk("abort_quotient",  quotient,  32'hFFFFFFFF);
    chk("abort_remainder", remainder, 32'hFFFFFFF8);
    watch_no_done("abort", 40);
    $display("abort sequence q=%h r=%h", quotient, remainder);

    // Hold enable past done; operands change after accept and must be ignored.
    start_op(1'b1, 32'd100, 32'd7);
    tick();
    a = 32'd1; b = 32'd1;
    n = 1;
    while (!done && n < 80) begin
      tick();
      n++;
    end
    chk("hold_latency",   32'(n),   32'd34);
    chk("hold_quotient",  quotient, 32'd14);
    chk("hold_remainder", remainder, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_done_%0d", k), 32'(done), 32'd1);
      chk($sformatf("hold_busy_%0d", k), 32'(busy), 32'd0);
      chk($sformatf("hold_q_%0d", k),    quotient,  32'd14);
      chk($sformatf("hold_r_%0d", k),    remainder, 32'd2);
    end
    enable = 1'b0;
    tick();
    chk("hold_done_low", 32'(done), 32'd0);
    start_op(1'b1, 32'd9, 32'd3);
    wait_done("reaccept", n);
    chk("reaccept_latency",   32'(n),    32'd34);
    chk("reaccept_quotient",  quotient,  32'd3);
    chk("reaccept_remainder", remainder, 32'd0);
    enable = 1'b0;
    tick();
    $display("hold sequence q=%h r=%h lat=%0d", quotient, remainder, n);

    // Reset at T+10 with enable still high: everything clears, nothing is accepted.
    start_op(1'b1, 32'd1000, 32'd10);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_quotient",  quotient,  32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_done",      32'(done), 32'd0);
    chk("midrst_busy",      32'(busy), 32'd0);
    tick();
    chk("midrst_no_accept", 32'(busy), 32'd0);
    rst    = 1'b0;
    enable = 1'b0;
    watch_no_done("midrst", 40);
    chk("midrst_q_after", quotient, 32'd0);
    $display("reset sequence q=%h r=%h", quotient, remainder);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
